// File: rtl/ic_pkg.sv
// Shared interconnect definitions: bus widths and the response record carried
// from the peripheral responder back to the interconnect.
package ic_pkg;

    localparam int IC_ADDR_W = 32;
    localparam int IC_DATA_W = 32;
    localparam int IC_STRB_W = 4;

    typedef struct packed {
        logic                 error;
        logic [IC_DATA_W-1:0] rdata;
    } ic_rsp_t;

endpackage

// File: rtl/ic_rsp_fifo.sv
// In-order response FIFO. Pointers wrap naturally (DEPTH is a power of two);
// full/empty come from the occupancy count.
module ic_rsp_fifo
    import ic_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          push,
    input  logic          pop,
    input  ic_rsp_t       wr_data,
    output ic_rsp_t       rd_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    ic_rsp_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge g_clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rd_data = empty ? '0 : mem[rd_ptr];

    push_never_full: assert property (@(posedge g_clk) disable iff (!g_resetn) !(push && full));

endmodule

// File: rtl/ic_periph_responder.sv
// Peripheral-side responder: credit-limited request acceptance, single-cycle
// device access and in-order responses. Optional address range check: IC_RSP_RANGE_CHECK_EN.
module ic_periph_responder
    import ic_pkg::*;
#(
    parameter int          RSP_DEPTH  = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter logic [31:0] RANGE_SIZE = 32'h1000
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    input  logic                 periph_req,
    output logic                 periph_gnt,
    input  logic                 periph_wen,
    input  logic [IC_STRB_W-1:0] periph_strb,
    input  logic [IC_ADDR_W-1:0] periph_addr,
    input  logic [IC_DATA_W-1:0] periph_wdata,
    output logic                 periph_recv,
    input  logic                 periph_ack,
    output logic [IC_DATA_W-1:0] periph_rdata,
    output logic                 periph_error,
    output logic                 dev_en,
    output logic                 dev_wen,
    output logic [IC_STRB_W-1:0] dev_strb,
    output logic [IC_ADDR_W-1:0] dev_addr,
    output logic [IC_DATA_W-1:0] dev_wdata,
    input  logic [IC_DATA_W-1:0] dev_rdata,
    input  logic                 dev_error
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] MAX_CREDITS = CW'(RSP_DEPTH);

    logic [CW-1:0] credits;
    logic          accept;
    logic          pop;
    logic          err_local;
    logic          inf_v;
    logic          inf_wen;
    logic          inf_err;
    ic_rsp_t       inf_rsp;
    ic_rsp_t       fifo_head;
    ic_rsp_t       head;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          unused_fifo_full;
    logic [CW-1:0] unused_fifo_count;

`ifdef IC_RSP_RANGE_CHECK_EN
    // 33-bit compare so BASE_ADDR + RANGE_SIZE cannot wrap past 2^32.
    logic [IC_ADDR_W:0] addr_ext;
    logic [IC_ADDR_W:0] lo_ext;
    logic [IC_ADDR_W:0] hi_ext;
    assign addr_ext  = {1'b0, periph_addr};
    assign lo_ext    = {1'b0, BASE_ADDR};
    assign hi_ext    = lo_ext + {1'b0, RANGE_SIZE};
    assign err_local = (addr_ext < lo_ext) || (addr_ext >= hi_ext);
`else
    logic unused_range;
    assign unused_range = ^{BASE_ADDR, RANGE_SIZE};
    assign err_local    = 1'b0;
`endif

    assign periph_gnt = (credits < MAX_CREDITS);
    assign accept     = periph_req && periph_gnt;

    assign dev_en    = accept && !err_local;
    assign dev_wen   = periph_wen;
    assign dev_strb  = periph_strb;
    assign dev_addr  = periph_addr;
    assign dev_wdata = periph_wdata;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            credits <= '0;
            inf_v   <= 1'b0;
        end else begin
            inf_v <= accept;
            case ({accept, pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (accept) begin
            inf_wen <= periph_wen;
            inf_err <= err_local;
        end
    end

    // Device stage: response formed from the device's next-cycle data.
    assign inf_rsp.error = dev_error | inf_err;
    assign inf_rsp.rdata = (inf_wen || inf_err) ? '0 : dev_rdata;

    // The in-flight entry is the youngest response; it is presented directly
    // when the FIFO is empty so that a response is visible the cycle after accept.
    assign periph_recv  = !fifo_empty || inf_v;
    assign head         = !fifo_empty ? fifo_head : (inf_v ? inf_rsp : '0);
    assign periph_rdata = head.rdata;
    assign periph_error = head.error;

    assign pop       = periph_recv && periph_ack;
    assign fifo_pop  = pop && !fifo_empty;
    assign fifo_push = inf_v && !(pop && fifo_empty);

    ic_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .wr_data  (inf_rsp),
        .rd_data  (fifo_head),
        .empty    (fifo_empty),
        .full     (unused_fifo_full),
        .count    (unused_fifo_count)
    );

endmodule
